// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pkg
//  Purpose  : Shared direction codes, mode codes, grid defaults and a small
//             helper for the snake game controller.
//  Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Direction codes; bit 1 identifies the axis (0 vertical, 1 horizontal)
    localparam logic [1:0] c_dir_up    = 2'd0;
    localparam logic [1:0] c_dir_down  = 2'd1;
    localparam logic [1:0] c_dir_left  = 2'd2;
    localparam logic [1:0] c_dir_right = 2'd3;

    // Externally visible game mode codes
    localparam logic [1:0] c_mode_idle = 2'd0;
    localparam logic [1:0] c_mode_play = 2'd1;
    localparam logic [1:0] c_mode_over = 2'd2;

    // Grid and game defaults
    localparam int          c_grid_w_def    = 40;
    localparam int          c_grid_h_def    = 30;
    localparam int          c_max_score_def = 15;
    localparam logic [11:0] c_lfsr_seed_def = 12'hACE;

    // True when both directions lie on the same axis (reversal or repeat)
    function automatic logic same_axis(input logic [1:0] a, input logic [1:0] b);
        return a[1] == b[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : snake_game_ctrl_if
//  Purpose  : Control/status bundle between the snake datapath/user inputs
//             (master) and the game controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface snake_game_ctrl_if;

    logic       tick_en;
    logic       start;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic       collide;

    logic [1:0] mode;
    logic       step;
    logic [1:0] dir;
    logic       eat;
    logic [5:0] apple_x;
    logic [5:0] apple_y;
    logic [3:0] score;

    modport master (
        output tick_en, start, up, down, left, right, head_x, head_y, collide,
        input  mode, step, dir, eat, apple_x, apple_y, score
    );

    modport slave (
        input  tick_en, start, up, down, left, right, head_x, head_y, collide,
        output mode, step, dir, eat, apple_x, apple_y, score
    );

endinterface
`default_nettype wire

// File: rtl/snake_apple_gen.sv
`default_nettype none
// ============================================================================
//  Module   : snake_apple_gen
//  Purpose  : Free-running 12-bit Fibonacci LFSR (x^12+x^6+x^4+x+1) and the
//             apple candidate acceptance test (in playfield, not on head).
//  Revision : 1.0 - initial release
// ============================================================================
module snake_apple_gen
    import snake_pkg::*;
#(
    parameter int          GRID_W    = c_grid_w_def,
    parameter int          GRID_H    = c_grid_h_def,
    parameter logic [11:0] LFSR_SEED = c_lfsr_seed_def
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] head_x,
    input  logic [5:0] head_y,
    output logic [5:0] cand_x,
    output logic [5:0] cand_y,
    output logic       cand_ok
);

    localparam logic [5:0] c_x_max = 6'(GRID_W - 2);
    localparam logic [5:0] c_y_max = 6'(GRID_H - 2);

    logic [11:0] r_lfsr;
    logic        w_fb;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_on_head;

    assign w_fb = r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0];

    // LFSR advances every cycle regardless of game state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[10:0], w_fb};
        end
    end

    // Candidate is accepted only inside the walls and off the snake head
    always_comb begin
        cand_x    = r_lfsr[5:0];
        cand_y    = r_lfsr[11:6];
        w_in_x    = (cand_x >= 6'd1) && (cand_x <= c_x_max);
        w_in_y    = (cand_y >= 6'd1) && (cand_y <= c_y_max);
        w_on_head = (cand_x == head_x) && (cand_y == head_y);
        cand_ok   = w_in_x && w_in_y && !w_on_head;
    end

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : snake_game_ctrl
//  Purpose  : Snake game controller: game FSM, step pacing, direction
//             commit with reversal guard, apple placement, scoring.
//  Revision : 1.0 - initial release
// ============================================================================
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int          GRID_W    = c_grid_w_def,
    parameter int          GRID_H    = c_grid_h_def,
    parameter int          MAX_SCORE = c_max_score_def,
    parameter logic [11:0] LFSR_SEED = c_lfsr_seed_def
) (
    input  logic             clk,
    input  logic             rst,
    snake_game_ctrl_if.slave bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_place = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_over  = 2'd3;

    localparam logic [3:0] c_score_max = 4'(MAX_SCORE);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_step;
    logic       r_eat;
    logic [1:0] r_dir;
    logic [1:0] r_pend;
    logic [5:0] r_apple_x;
    logic [5:0] r_apple_y;
    logic [3:0] r_score;

    logic [5:0] w_cand_x;
    logic [5:0] w_cand_y;
    logic       w_cand_ok;
    logic       w_eat_hit;
    logic       w_step_nxt;
    logic       w_req_vld;
    logic [1:0] w_req;
    logic [3:0] w_score_inc;

    snake_apple_gen #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .LFSR_SEED (LFSR_SEED)
    ) u_apple_gen (
        .clk     (clk),
        .rst     (rst),
        .head_x  (bus.head_x),
        .head_y  (bus.head_y),
        .cand_x  (w_cand_x),
        .cand_y  (w_cand_y),
        .cand_ok (w_cand_ok)
    );

    // Eat is suppressed in the step cycle so the head move is seen exactly once
    always_comb begin
        w_eat_hit   = (r_state == c_st_run) && !bus.collide &&
                      (bus.head_x == r_apple_x) && (bus.head_y == r_apple_y) &&
                      !r_step;
        w_score_inc = (r_score >= c_score_max) ? r_score : r_score + 4'd1;
    end

    // Priority encode simultaneous direction pulses: up > down > left > right
    always_comb begin
        w_req_vld = bus.up | bus.down | bus.left | bus.right;
        if (bus.up) begin
            w_req = c_dir_up;
        end else if (bus.down) begin
            w_req = c_dir_down;
        end else if (bus.left) begin
            w_req = c_dir_left;
        end else begin
            w_req = c_dir_right;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; collision outranks eating
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.start) w_state_nxt = c_st_place;
            end
            c_st_place: begin
                if (w_cand_ok) w_state_nxt = c_st_run;
            end
            c_st_run: begin
                if (bus.collide) begin
                    w_state_nxt = c_st_over;
                end else if (w_eat_hit) begin
                    w_state_nxt = (w_score_inc == c_score_max) ? c_st_over : c_st_place;
                end
            end
            default: begin
                if (bus.start) w_state_nxt = c_st_idle;
            end
        endcase
    end

    // FSM output decode: PLACE and RUN both report PLAY
    always_comb begin
        case (r_state)
            c_st_idle: bus.mode = c_mode_idle;
            c_st_over: bus.mode = c_mode_over;
            default:   bus.mode = c_mode_play;
        endcase
    end

    // A tick only yields a step if the game is still running next cycle
    assign w_step_nxt = (r_state == c_st_run) && bus.tick_en && (w_state_nxt == c_st_run);

    // Step/eat pulses, direction commit, apple load and score
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step    <= 1'b0;
            r_eat     <= 1'b0;
            r_dir     <= c_dir_down;
            r_pend    <= c_dir_down;
            r_apple_x <= 6'd0;
            r_apple_y <= 6'd0;
            r_score   <= 4'd0;
        end else begin
            r_step <= w_step_nxt;
            r_eat  <= w_eat_hit;
            if ((r_state == c_st_idle) && bus.start) begin
                r_dir   <= c_dir_down;
                r_pend  <= c_dir_down;
                r_score <= 4'd0;
            end else begin
                if (w_step_nxt) begin
                    r_dir <= r_pend;
                end
                // Guard against the committed direction so two quick turns cannot reverse
                if ((r_state != c_st_over) && w_req_vld && !same_axis(w_req, r_dir)) begin
                    r_pend <= w_req;
                end
                if (w_eat_hit) begin
                    r_score <= w_score_inc;
                end
            end
            if ((r_state == c_st_place) && w_cand_ok) begin
                r_apple_x <= w_cand_x;
                r_apple_y <= w_cand_y;
            end
        end
    end

    assign bus.step    = r_step;
    assign bus.eat     = r_eat;
    assign bus.dir     = r_dir;
    assign bus.apple_x = r_apple_x;
    assign bus.apple_y = r_apple_y;
    assign bus.score   = r_score;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_game_ctrl
//  Purpose  : Self-checking bench for snake_game_ctrl: game-rule reference
//             model, directed vector table and hand sequences, random phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snake_game_ctrl;

    localparam int          GW   = 40;
    localparam int          GH   = 30;
    localparam int          MAXS = 15;
    localparam logic [11:0] SEED = 12'hACE;

    logic clk;
    logic rst;
    snake_game_ctrl_if bus_i ();

    snake_game_ctrl #(
        .GRID_W    (GW),
        .GRID_H    (GH),
        .MAX_SCORE (MAXS),
        .LFSR_SEED (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst, tick, start, up, down, left, right, collide;
        int hx, hy;
    } in_t;

    typedef struct {
        bit tick, start, up, down, left, right, on_apple;
        int e_mode, e_step, e_dir, e_eat, e_score;
    } vec_t;

    typedef enum {S_IDLE, S_PLACE, S_RUN, S_OVER} gstate_t;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model of the game rules
    gstate_t     m_state = S_IDLE;
    int          m_step = 0, m_dir = 1, m_pend = 1, m_eat = 0;
    int          m_ax = 0, m_ay = 0, m_score = 0;
    logic [11:0] m_lfsr = SEED;

    // Pseudo-random source: shift left, feed in parity of taps 12,6,4,1
    function automatic logic [11:0] lfsr_next(input logic [11:0] l);
        return {l[10:0], ^(l & 12'h829)};
    endfunction

    function automatic int mode_of(input gstate_t s);
        if (s == S_IDLE) return 0;
        if (s == S_OVER) return 2;
        return 1;
    endfunction

    task automatic model_update(input in_t i);
        gstate_t ns;
        int cx, cy, req, nscore, new_step, new_dir, new_pend;
        bit ok, hit;
        if (i.rst) begin
            m_state = S_IDLE; m_step = 0; m_dir = 1; m_pend = 1; m_eat = 0;
            m_ax = 0; m_ay = 0; m_score = 0; m_lfsr = SEED;
            return;
        end
        cx  = int'(m_lfsr[5:0]);
        cy  = int'(m_lfsr[11:6]);
        ok  = (cx >= 1) && (cx <= GW - 2) && (cy >= 1) && (cy <= GH - 2) &&
              !((cx == i.hx) && (cy == i.hy));
        hit = (m_state == S_RUN) && !i.collide && (i.hx == m_ax) && (i.hy == m_ay) && (m_step == 0);
        nscore = (m_score + 1 > MAXS) ? MAXS : m_score + 1;
        req = -1;
        if (i.right) req = 3;
        if (i.left)  req = 2;
        if (i.down)  req = 1;
        if (i.up)    req = 0;
        ns = m_state;
        case (m_state)
            S_IDLE:  if (i.start) ns = S_PLACE;
            S_PLACE: if (ok) ns = S_RUN;
            S_RUN: begin
                if (i.collide) ns = S_OVER;
                else if (hit) ns = (nscore == MAXS) ? S_OVER : S_PLACE;
            end
            default: if (i.start) ns = S_IDLE;
        endcase
        new_step = (m_state == S_RUN && i.tick && ns == S_RUN) ? 1 : 0;
        new_dir  = new_step ? m_pend : m_dir;
        new_pend = m_pend;
        if (m_state != S_OVER && req >= 0 && (req / 2) != (m_dir / 2)) new_pend = req;
        if (m_state == S_IDLE && i.start) begin
            new_pend = 1; new_dir = 1; m_score = 0;
        end
        if (m_state == S_PLACE && ok) begin
            m_ax = cx; m_ay = cy;
        end
        if (hit) m_score = nscore;
        m_eat   = hit ? 1 : 0;
        m_step  = new_step;
        m_dir   = new_dir;
        m_pend  = new_pend;
        m_state = ns;
        m_lfsr  = lfsr_next(m_lfsr);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_mode",    int'(bus_i.mode),    mode_of(m_state));
        chk("model_step",    int'(bus_i.step),    m_step);
        chk("model_dir",     int'(bus_i.dir),     m_dir);
        chk("model_eat",     int'(bus_i.eat),     m_eat);
        chk("model_apple_x", int'(bus_i.apple_x), m_ax);
        chk("model_apple_y", int'(bus_i.apple_y), m_ay);
        chk("model_score",   int'(bus_i.score),   m_score);
    endtask

    function automatic in_t nop();
        in_t i;
        i = '{rst: 0, tick: 0, start: 0, up: 0, down: 0, left: 0, right: 0,
              collide: 0, hx: 0, hy: 0};
        return i;
    endfunction

    // One clock: drive, let the edge happen, advance the model, compare
    task automatic cyc(input in_t i);
        rst           = i.rst;
        bus_i.tick_en = i.tick;
        bus_i.start   = i.start;
        bus_i.up      = i.up;
        bus_i.down    = i.down;
        bus_i.left    = i.left;
        bus_i.right   = i.right;
        bus_i.collide = i.collide;
        bus_i.head_x  = 6'(i.hx);
        bus_i.head_y  = 6'(i.hy);
        @(posedge clk);
        model_update(i);
        #1;
        compare_model();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mode"},    int'(bus_i.mode),    0);
        chk({tag, "_step"},    int'(bus_i.step),    0);
        chk({tag, "_dir"},     int'(bus_i.dir),     1);
        chk({tag, "_eat"},     int'(bus_i.eat),     0);
        chk({tag, "_apple_x"}, int'(bus_i.apple_x), 0);
        chk({tag, "_apple_y"}, int'(bus_i.apple_y), 0);
        chk({tag, "_score"},   int'(bus_i.score),   0);
    endtask

    // Idle with the head parked until the apple is placed (64-cycle bound)
    task automatic run_until_run(input int hx, input int hy);
        in_t i;
        int  n;
        bit  valid;
        i = nop(); i.hx = hx; i.hy = hy;
        n = 0;
        while (m_state != S_RUN && n < 64) begin
            cyc(i);
            n++;
        end
        if (m_state != S_RUN) chk("place_timeout", n, 0);
        valid = (bus_i.apple_x >= 6'd1) && (int'(bus_i.apple_x) <= GW - 2) &&
                (bus_i.apple_y >= 6'd1) && (int'(bus_i.apple_y) <= GH - 2) &&
                !((int'(bus_i.apple_x) == hx) && (int'(bus_i.apple_y) == hy));
        chk("apple_valid", int'(valid), 1);
    endtask

    function automatic vec_t mk(input bit tk, st, u, d, l, r, oa,
                                input int em, es, ed, ee, esc);
        vec_t v;
        v = '{tick: tk, start: st, up: u, down: d, left: l, right: r, on_apple: oa,
              e_mode: em, e_step: es, e_dir: ed, e_eat: ee, e_score: esc};
        return v;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[17];
        in_t  i;
        int   lx, ly;

        //          tk st up dn lf rt oa   mode step dir eat score
        tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0,  1,   0,   1,  0,  0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  1,   1,   1,  0,  0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  1,   0,   1,  0,  0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0,  1,   0,   1,  0,  0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0,  1,   0,   1,  0,  0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,  1,   1,   2,  0,  0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  1,   0,   2,  0,  0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0,  1,   0,   2,  0,  0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0,  1,   0,   2,  0,  0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0,  1,   1,   0,  0,  0);
        tbl[10] = mk(1, 0, 0, 1, 0, 0, 0,  1,   1,   0,  0,  0);
        tbl[11] = mk(0, 0, 0, 0, 1, 1, 0,  1,   0,   0,  0,  0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0,  1,   0,   0,  0,  0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,  1,   1,   2,  0,  0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1,  1,   0,   2,  0,  0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1,  1,   0,   2,  1,  1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1,  1,   0,   2,  0,  1);

        // Reset, then start: IDLE -> PLAY, apple placed legally
        i = nop(); i.rst = 1;
        cyc(i);
        check_reset_vals("rst");
        i = nop(); i.start = 1;
        cyc(i);
        chk("start_mode", int'(bus_i.mode), 1);
        chk("start_dir",  int'(bus_i.dir),  1);
        run_until_run(0, 0);

        // Directed vectors from a fresh RUN state
        lx = 0; ly = 0;
        for (int r = 0; r < 17; r++) begin
            i = nop();
            i.tick = tbl[r].tick; i.start = tbl[r].start;
            i.up = tbl[r].up; i.down = tbl[r].down;
            i.left = tbl[r].left; i.right = tbl[r].right;
            if (tbl[r].on_apple) begin i.hx = m_ax; i.hy = m_ay; end
            lx = i.hx; ly = i.hy;
            cyc(i);
            chk($sformatf("tbl%0d_mode", r),  int'(bus_i.mode),  tbl[r].e_mode);
            chk($sformatf("tbl%0d_step", r),  int'(bus_i.step),  tbl[r].e_step);
            chk($sformatf("tbl%0d_dir", r),   int'(bus_i.dir),   tbl[r].e_dir);
            chk($sformatf("tbl%0d_eat", r),   int'(bus_i.eat),   tbl[r].e_eat);
            chk($sformatf("tbl%0d_score", r), int'(bus_i.score), tbl[r].e_score);
        end

        // New apple must avoid the head that just ate; then collide beats eat
        run_until_run(lx, ly);
        i = nop(); i.collide = 1; i.hx = m_ax; i.hy = m_ay;
        cyc(i);
        chk("collide_mode",  int'(bus_i.mode),  2);
        chk("collide_eat",   int'(bus_i.eat),   0);
        chk("collide_score", int'(bus_i.score), 1);
        for (int k = 0; k < 3; k++) begin
            i = nop(); i.tick = 1; i.left = 1;
            cyc(i);
            chk("over_no_step", int'(bus_i.step), 0);
        end
        i = nop(); i.start = 1;
        cyc(i);
        chk("over_restart_mode",  int'(bus_i.mode),  0);
        chk("over_keep_score",    int'(bus_i.score), 1);
        cyc(i);
        chk("idle_start_score", int'(bus_i.score), 0);

        // Eat up to MAX_SCORE: last apple ends the game as a win
        lx = 0; ly = 0;
        for (int k = 1; k <= MAXS; k++) begin
            run_until_run(lx, ly);
            i = nop(); i.hx = m_ax; i.hy = m_ay;
            lx = i.hx; ly = i.hy;
            cyc(i);
            chk("win_eat",   int'(bus_i.eat),   1);
            chk("win_score", int'(bus_i.score), k);
            chk("win_mode",  int'(bus_i.mode),  (k < MAXS) ? 1 : 2);
        end
        i = nop();
        cyc(i);
        chk("win_eat_pulse", int'(bus_i.eat), 0);
        for (int k = 0; k < 3; k++) begin
            i = nop(); i.tick = 1;
            cyc(i);
            chk("win_no_step", int'(bus_i.step), 0);
        end
        i = nop(); i.start = 1;
        cyc(i);
        chk("win_idle_mode",  int'(bus_i.mode),  0);
        chk("win_idle_score", int'(bus_i.score), MAXS);
        cyc(i);
        chk("win_restart_score", int'(bus_i.score), 0);
        chk("win_restart_mode",  int'(bus_i.mode),  1);

        // Reset mid-PLACE and mid-RUN with competing inputs
        i = nop(); i.rst = 1; i.tick = 1; i.start = 1; i.left = 1;
        cyc(i);
        check_reset_vals("rst_place");
        i = nop(); i.start = 1;
        cyc(i);
        run_until_run(0, 0);
        i = nop(); i.tick = 1;
        cyc(i);
        chk("pre_rst_step", int'(bus_i.step), 1);
        i = nop(); i.rst = 1; i.tick = 1; i.collide = 1;
        cyc(i);
        check_reset_vals("rst_run");

        // Random phase against the reference model
        for (int c = 0; c < 3000; c++) begin
            i = nop();
            i.rst     = ($urandom_range(0, 499) == 0);
            i.tick    = ($urandom_range(0, 3) == 0);
            i.start   = ($urandom_range(0, 24) == 0);
            i.up      = ($urandom_range(0, 9) == 0);
            i.down    = ($urandom_range(0, 9) == 0);
            i.left    = ($urandom_range(0, 9) == 0);
            i.right   = ($urandom_range(0, 9) == 0);
            i.collide = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) begin
                i.hx = m_ax; i.hy = m_ay;
            end else begin
                i.hx = int'($urandom_range(0, 63));
                i.hy = int'($urandom_range(0, 63));
            end
            cyc(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter GRID_W, default 40: playfield width in cells; playable x range is 1..GRID_W-2.
REQ-002 Parameter GRID_H, default 30: playfield height in cells; playable y range is 1..GRID_H-2.
REQ-003 Parameter MAX_SCORE, default 15: score at which the game ends as a win.
REQ-004 Parameter LFSR_SEED, default 12'hACE: non-zero reset value of the apple LFSR.
REQ-005 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 tick_en  in  1  one-cycle game-rate pulse (nominally 4 Hz).
REQ-008 start  in  1  debounced one-cycle start/restart pulse.
REQ-009 up, down, left, right  in  1 each  debounced one-cycle direction pulses.
REQ-010 head_x, head_y  in  6 each  registered snake head position.
REQ-011 collide  in  1  snake datapath reports wall or self hit.
REQ-012 mode  out  2  game state: 0 IDLE, 1 PLAY, 2 OVER.
REQ-013 step  out  1  one-cycle pulse commanding the snake to advance one cell.
REQ-014 dir  out  2  committed direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
REQ-015 eat  out  1  one-cycle pulse when head reaches apple.
REQ-016 apple_x, apple_y  out  6 each  current apple cell.
REQ-017 score  out  4  apples eaten, saturating at MAX_SCORE.

Function
REQ-018 FSM states SHALL be IDLE, PLACE, RUN, OVER; mode SHALL be 0 in IDLE, 1 in PLACE/RUN, 2 in OVER.
REQ-019 IDLE: start SHALL clear score, set dir and pending direction to DOWN, and go to PLACE next cycle.
REQ-020 A 12-bit maximal-length Fibonacci LFSR SHALL advance every cycle in all states.
REQ-021 PLACE: candidate x = lfsr[5:0], y = lfsr[11:6]; accepted when in playable range and not equal to (head_x, head_y); on accept apple_x/apple_y load the candidate and state goes to RUN next cycle; otherwise retry next cycle.
REQ-022 tick_en SHALL be ignored in IDLE, PLACE and OVER; step SHALL be 0 outside RUN.
REQ-023 RUN: tick_en SHALL produce step = 1 on the following cycle (latency 1) and commit dir <= pending direction in that same cycle.
REQ-024 Direction pulses SHALL update the pending direction in any state except OVER; simultaneous pulses resolve with priority up > down > left > right.
REQ-025 A request on the same axis as committed dir (reversal or repeat) SHALL be ignored; checking against committed, not pending, dir prevents two turns within one tick from reversing.
REQ-026 RUN, collide = 1: go to OVER next cycle; no eat, no score change.
REQ-027 RUN, collide = 0 and head equals apple and step = 0: eat = 1 for one cycle, score +1, go to PLACE, or go to OVER if the new score equals MAX_SCORE.
REQ-028 collide SHALL take priority over eat; eat evaluation SHALL be suppressed in the step cycle so the snake's one-cycle head update is not missed or double-counted.
REQ-029 score SHALL never exceed MAX_SCORE or wrap.
REQ-030 OVER: outputs hold; start returns to IDLE next cycle (score retained until the next IDLE start).
REQ-031 start in PLACE or RUN SHALL be ignored.

Reset
REQ-032 rst SHALL force state IDLE, mode 0, step 0, dir 1 (DOWN), pending DOWN, eat 0, apple_x 0, apple_y 0, score 0, lfsr LFSR_SEED, overriding all other inputs in that cycle, including mid-PLACE and mid-RUN.

Structure
REQ-033 Direction codes, mode codes and grid defaults SHALL live in shared package snake_pkg.
REQ-034 The LFSR and candidate-acceptance logic SHALL be sub-module snake_apple_gen.

Verification
REQ-035 rst, then start -> mode 0, then 1; apple within x 1..38, y 1..28 and not equal to head within 64 cycles; dir = 1.
REQ-036 RUN, dir DOWN, left pulse then up pulse before tick_en -> next step cycle commits dir = 2; a lone up pulse while dir = 1 -> dir stays 1.
REQ-037 head set equal to apple in a non-step RUN cycle -> eat high exactly 1 cycle, score 0 -> 1, state PLACE, new apple differs from head.
REQ-038 collide and head equal to apple in the same cycle -> mode 2 next cycle, eat 0, score unchanged.
REQ-039 Score 14, eat -> score 15, mode 2; further tick_en gives no step; start -> mode 0; start -> score 0.
REQ-040 rst asserted during PLACE and during RUN with tick_en -> all outputs at the REQ-032 values the next cycle, step 0.
